// File: rtl/jtag_scan_master.sv
// jtag_scan_master: turns one scan command (TAP reset, IR scan, DR scan or
// idle clocking) into a TCK/TMS/TDI sequence and returns the captured TDO bits.
module jtag_scan_master #(
    parameter int IR_LEN  = 6,
    parameter int DR_MAX  = 41,
    parameter int CLK_DIV = 4,
    parameter int LW      = $clog2(DR_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LW-1:0]     cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              rsp_err,
    output logic              tap_sync,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam int CW = $clog2(DR_MAX + IR_LEN + 8);
    localparam int DW = $clog2(2 * CLK_DIV);

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_DR  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [LW-1:0]     len_q;
    logic [DR_MAX-1:0] data_q;
    logic [DR_MAX-1:0] sel_q;     // one-hot: bit index of the current/next shift cycle
    logic [DR_MAX-1:0] rsp_q;
    logic [CW-1:0]     k_q;       // TCK cycle index within the command
    logic [DW-1:0]     div_q;     // clk count within the TCK cycle
    logic              tck_q, tms_q, tdi_q, err_q, sync_q;

    logic              reject, rise, fall;
    int unsigned       nsh, pre, total, kc, kn;
    logic              shift_cur, shift_nxt, tms_nxt, last_cyc;
    logic [DR_MAX-1:0] sel_nx;

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_q;
    assign rsp_err   = err_q;
    assign tap_sync  = sync_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    // TCK edges: high phase starts after CLK_DIV low cycles, cycle ends after 2*CLK_DIV
    assign rise = (state_q == S_RUN) && (div_q == DW'(CLK_DIV - 1));
    assign fall = (state_q == S_RUN) && (div_q == DW'(2 * CLK_DIV - 1));

    // Command legality: scans need a known TAP state and a sane length
    always_comb begin
        reject = 1'b0;
        if (cmd_op != OP_RST && !sync_q) reject = 1'b1;
        if (cmd_op == OP_DR && (cmd_len == '0 || 32'(cmd_len) > DR_MAX)) reject = 1'b1;
        if (cmd_op == 2'b11 && cmd_len == '0) reject = 1'b1;
    end

    // Per-op TMS schedule: shift window [pre, pre+nsh), total K cycles
    always_comb begin
        nsh   = 0;
        pre   = 0;
        total = 32'(len_q);
        case (op_q)
            OP_RST:  total = 6;
            OP_IR:   begin nsh = IR_LEN;       pre = 4; total = IR_LEN + 6;       end
            OP_DR:   begin nsh = 32'(len_q);   pre = 3; total = 32'(len_q) + 5;   end
            default: ;
        endcase
        kc        = 32'(k_q);
        kn        = kc + 1;
        shift_cur = (kc >= pre) && (kc < pre + nsh);
        shift_nxt = (kn >= pre) && (kn < pre + nsh);
        last_cyc  = (kn == total);
        case (op_q)
            OP_RST:  tms_nxt = (kn < 5);
            OP_IR:   tms_nxt = (kn < 2) || (kn == pre + nsh - 1) || (kn == pre + nsh);
            OP_DR:   tms_nxt = (kn == pre + nsh - 1) || (kn == pre + nsh);
            default: tms_nxt = 1'b0;
        endcase
        sel_nx = shift_cur ? (sel_q << 1) : sel_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = reject ? S_RESP : S_RUN;
            S_RUN:   if (fall && last_cyc) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath: command latch, TCK generation, TMS/TDI drive, TDO capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            len_q  <= '0;
            data_q <= '0;
            sel_q  <= '0;
            rsp_q  <= '0;
            k_q    <= '0;
            div_q  <= '0;
            tck_q  <= 1'b0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
            err_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    op_q   <= cmd_op;
                    len_q  <= cmd_len;
                    data_q <= cmd_data;
                    sel_q  <= DR_MAX'(1);
                    rsp_q  <= '0;
                    k_q    <= '0;
                    div_q  <= '0;
                    tck_q  <= 1'b0;
                    tdi_q  <= 1'b0;
                    err_q  <= reject;
                    // First TMS of every schedule is 1 except idle clocking
                    if (!reject) tms_q <= (cmd_op != 2'b11);
                end
                S_RUN: begin
                    if (fall) begin
                        div_q <= '0;
                        tck_q <= 1'b0;
                        sel_q <= sel_nx;
                        if (last_cyc) begin
                            tdi_q <= 1'b0;
                            if (op_q == OP_RST) sync_q <= 1'b1;
                        end else begin
                            k_q   <= k_q + CW'(1);
                            tms_q <= tms_nxt;
                            tdi_q <= shift_nxt ? |(data_q & sel_nx) : 1'b0;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                        if (rise) begin
                            tck_q <= 1'b1;
                            if (shift_cur) rsp_q <= rsp_q | (sel_q & {DR_MAX{tdo}});
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a small IEEE 1149.1 TAP target model
// (IDCODE at IR 0x01, 41-bit DMI at IR 0x11, bypass otherwise).
module tb_jtag_scan_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = '0;
    logic [40:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [40:0] rsp_data;
    logic        rsp_err, tap_sync, tck, tms, tdi;
    logic        tdo = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    jtag_scan_master #(.IR_LEN(6), .DR_MAX(41), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .tap_sync(tap_sync), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // TCK pulse counter and TMS history (most recent pulse at bit 0)
    int          pulses = 0;
    logic [63:0] tms_hist = '0;
    always @(posedge tck) begin
        pulses   <= pulses + 1;
        tms_hist <= {tms_hist[62:0], tms};
    end

    // TAP target model
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PSDR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PSIR, T_EX2IR, T_UPIR
    } tap_t;

    tap_t        tap_st = T_SHDR;
    logic [5:0]  tap_ir = 6'h01;
    logic [5:0]  ir_sr = '0;
    logic [63:0] dr_sr = '0;
    logic [40:0] dmi_upd = '0;
    logic        halted = 1'b0;
    int          drlen;

    assign drlen = (tap_ir == 6'h01) ? 32 : (tap_ir == 6'h11) ? 41 : 1;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PSDR;
            T_PSDR:  return m ? T_EX2DR : T_PSDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PSIR;
            T_PSIR:  return m ? T_EX2IR : T_PSIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            T_TLR:   tap_ir <= 6'h01;
            T_CAPIR: ir_sr  <= 6'b000001;
            T_SHIR:  ir_sr  <= {tdi, ir_sr[5:1]};
            T_UPIR:  tap_ir <= ir_sr;
            T_CAPDR: dr_sr  <= (tap_ir == 6'h01) ? 64'h1BEEF001 :
                               (tap_ir == 6'h11) ? 64'h123456789AB : 64'h0;
            T_SHDR:  dr_sr  <= (dr_sr >> 1) | (64'(tdi) << (drlen - 1));
            T_UPDR:  if (tap_ir == 6'h11) begin
                dmi_upd <= dr_sr[40:0];
                if (dr_sr[40:34] == 7'h10 && dr_sr[1:0] == 2'b10 && dr_sr[33]) halted <= 1'b1;
            end
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        if (tap_st == T_SHIR)      tdo <= ir_sr[0];
        else if (tap_st == T_SHDR) tdo <= dr_sr[0];
    end

    // Issue one command, wait (bounded) for rsp_valid; lat counts edges from the
    // sampling edge, np counts TCK pulses seen
    task automatic run_cmd(input logic [1:0] op, input int len, input logic [40:0] data,
                           output int lat, output int np);
        int p0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 6'(len); cmd_data = data;
        p0 = pulses;
        @(posedge clk); lat = 1; #1; cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 1000) begin
            @(posedge clk); lat++; #1;
        end
        np = pulses - p0;
    endtask

    task automatic ack();
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (tck !== 1'b0)       begin miscompares++; $display("FAIL reset_tck got %b want 0", tck); end
        vectors++; if (tms !== 1'b1)       begin miscompares++; $display("FAIL reset_tms got %b want 1", tms); end
        vectors++; if (tdi !== 1'b0)       begin miscompares++; $display("FAIL reset_tdi got %b want 0", tdi); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vectors++; if (rsp_data !== '0)    begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        vectors++; if (rsp_err !== 1'b0)   begin miscompares++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        vectors++; if (tap_sync !== 1'b0)  begin miscompares++; $display("FAIL reset_tap_sync got %b want 0", tap_sync); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reject_nosync();
        int lat, np;
        run_cmd(2'b10, 32, 41'hDEADBEEF, lat, np);
        vectors++; if (lat !== 1)          begin miscompares++; $display("FAIL nosync_latency got %0d want 1", lat); end
        vectors++; if (rsp_err !== 1'b1)   begin miscompares++; $display("FAIL nosync_err got %b want 1", rsp_err); end
        vectors++; if (np !== 0)           begin miscompares++; $display("FAIL nosync_tck got %0d pulses want 0", np); end
        vectors++; if (rsp_data !== '0)    begin miscompares++; $display("FAIL nosync_data got %h want 0", rsp_data); end
        ack();
    endtask

    task automatic test_tap_reset(input string tag);
        int lat, np;
        run_cmd(2'b00, 0, '0, lat, np);
        vectors++; if (lat !== 25)         begin miscompares++; $display("FAIL %s_latency got %0d want 25", tag, lat); end
        vectors++; if (np !== 6)           begin miscompares++; $display("FAIL %s_pulses got %0d want 6", tag, np); end
        vectors++; if (tms_hist[5:0] !== 6'b111110) begin miscompares++; $display("FAIL %s_tms_seq got %b want 111110", tag, tms_hist[5:0]); end
        vectors++; if (tap_sync !== 1'b1)  begin miscompares++; $display("FAIL %s_tap_sync got %b want 1", tag, tap_sync); end
        vectors++; if (tap_st !== T_RTI)   begin miscompares++; $display("FAIL %s_tap_state got %0d want %0d", tag, tap_st, T_RTI); end
        vectors++; if (rsp_err !== 1'b0 || rsp_data !== '0) begin miscompares++; $display("FAIL %s_rsp got err=%b data=%h want 0/0", tag, rsp_err, rsp_data); end
        ack();
    endtask

    task automatic test_idcode();
        int lat, np;
        run_cmd(2'b10, 32, 41'hDEADBEEF, lat, np);
        vectors++; if (rsp_data !== 41'h1BEEF001) begin miscompares++; $display("FAIL idcode_data got %h want 1beef001", rsp_data); end
        vectors++; if (rsp_err !== 1'b0)   begin miscompares++; $display("FAIL idcode_err got %b want 0", rsp_err); end
        vectors++; if (lat !== 149)        begin miscompares++; $display("FAIL idcode_latency got %0d want 149", lat); end
        vectors++; if (np !== 37)          begin miscompares++; $display("FAIL idcode_pulses got %0d want 37", np); end
        vectors++; if (tap_st !== T_RTI)   begin miscompares++; $display("FAIL idcode_tap_state got %0d want %0d", tap_st, T_RTI); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat, np;
        logic [40:0] snap;
        logic bad;
        run_cmd(2'b10, 32, 41'h12345678, lat, np);
        snap = rsp_data;
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_data !== snap || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
        end
        vectors++; if (snap !== 41'h1BEEF001) begin miscompares++; $display("FAIL bp_data got %h want 1beef001", snap); end
        vectors++; if (bad !== 1'b0)       begin miscompares++; $display("FAIL bp_hold got unstable=%b want 0", bad); end
        ack();
        vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_ir_dmi();
        int lat, np;
        run_cmd(2'b01, 0, 41'h11, lat, np);
        vectors++; if (lat !== 49)         begin miscompares++; $display("FAIL ir_latency got %0d want 49", lat); end
        vectors++; if (rsp_data !== 41'h1) begin miscompares++; $display("FAIL ir_capture got %h want 1", rsp_data); end
        vectors++; if (tap_ir !== 6'h11)   begin miscompares++; $display("FAIL ir_value got %h want 11", tap_ir); end
        ack();
        run_cmd(2'b10, 41, {7'h10, 32'h80000001, 2'b10}, lat, np);
        vectors++; if (lat !== 185)        begin miscompares++; $display("FAIL dmi_latency got %0d want 185", lat); end
        vectors++; if (rsp_data !== 41'h123456789AB) begin miscompares++; $display("FAIL dmi_capture got %h want 123456789ab", rsp_data); end
        vectors++; if (dmi_upd !== {7'h10, 32'h80000001, 2'b10}) begin miscompares++; $display("FAIL dmi_update got %h want %h", dmi_upd, {7'h10, 32'h80000001, 2'b10}); end
        vectors++; if (halted !== 1'b1)    begin miscompares++; $display("FAIL dmi_halted got %b want 1", halted); end
        vectors++; if (tap_st !== T_RTI)   begin miscompares++; $display("FAIL dmi_tap_state got %0d want %0d", tap_st, T_RTI); end
        ack();
    endtask

    task automatic test_reject_len();
        logic [1:0] ops [3] = '{2'b10, 2'b10, 2'b11};
        int         lens[3] = '{0, 42, 0};
        int lat, np;
        for (int i = 0; i < 3; i++) begin
            run_cmd(ops[i], lens[i], 41'h1FFFF, lat, np);
            vectors++; if (rsp_err !== 1'b1 || lat !== 1 || np !== 0 || rsp_data !== '0) begin
                miscompares++;
                $display("FAIL reject_len%0d got err=%b lat=%0d pulses=%0d data=%h want 1/1/0/0", i, rsp_err, lat, np, rsp_data);
            end
            ack();
        end
    endtask

    task automatic test_back_to_back();
        int lat, np;
        rsp_ready = 1'b1;
        run_cmd(2'b11, 5, 41'h1F, lat, np);
        vectors++; if (lat !== 21)         begin miscompares++; $display("FAIL idle5_latency got %0d want 21", lat); end
        vectors++; if (np !== 5)           begin miscompares++; $display("FAIL idle5_pulses got %0d want 5", np); end
        vectors++; if (tms_hist[4:0] !== 5'b0) begin miscompares++; $display("FAIL idle5_tms got %b want 00000", tms_hist[4:0]); end
        vectors++; if (tap_st !== T_RTI || rsp_data !== '0) begin miscompares++; $display("FAIL idle5_state got tap=%0d data=%h want %0d/0", tap_st, rsp_data, T_RTI); end
        @(posedge clk); #1;
        vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL resp_one_cycle got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
        run_cmd(2'b11, 3, '0, lat, np);
        vectors++; if (lat !== 13 || np !== 3) begin miscompares++; $display("FAIL idle3 got lat=%0d pulses=%0d want 13/3", lat, np); end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd32; cmd_data = 41'h0F0F0F0F;
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if (tck !== 1'b0 || tms !== 1'b1) begin miscompares++; $display("FAIL midrst_pins got tck=%b tms=%b want 0/1", tck, tms); end
        vectors++; if (tap_sync !== 1'b0)  begin miscompares++; $display("FAIL midrst_tap_sync got %b want 0", tap_sync); end
        vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_hs got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || tck !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0)      begin miscompares++; $display("FAIL midrst_dropped got activity=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_reject_nosync();
        test_tap_reset("tapreset");
        test_idcode();
        test_backpressure();
        test_ir_dmi();
        test_reject_len();
        test_back_to_back();
        test_reset_mid();
        test_tap_reset("tapreset2");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
